pea_banks_store_xbar: RTL
=========================

PEA_BANKS_STORE_XBAR -- requirements
Module: pea_banks_store_xbar

Interface
REQ-001: Parameter N_PE, default 4, number of PE store inputs; equals the number of banks per stream; power of 2, at least 2.
REQ-002: Parameter DATA_W, default 32, store data width.
REQ-003: Derived value N_STG = log2(N_PE) is the number of pipeline stages, each built from 2-to-1 basic blocks.
REQ-004: clk_i  in  1  clock; all state updates on its rising edge.
REQ-005: rst_i  in  1  asynchronous, active-high reset.
REQ-006: pe_data_i  in  N_PE*DATA_W  store data per PE.
REQ-007: pe_valid_i  in  N_PE  store data valid per PE.
REQ-008: pe_ready_o  out  N_PE  all bits equal the global advance signal adv.
REQ-009: bank_sel_i  in  N_PE*N_STG  per-bank source-PE index; bank b selects PE bank_sel_i[b].
REQ-010: bank_data_o  out  N_PE*DATA_W  store data per bank.
REQ-011: bank_valid_o  out  N_PE  bank store valid.
REQ-012: bank_ready_i  in  N_PE  bank accepts the store.
REQ-013: idle_o  out  1  high when no pipeline register holds a valid entry.

Function
REQ-014: Each bank lane is a binary mux tree; stage s (0..N_STG-1) holds N_PE/2^(s+1) registered nodes per lane.
REQ-015: Stage-0 node k of lane b captures PE (2k + sel bit 0), where sel is bank_sel_i[b]; stage s uses sel bit s, selecting between nodes 2k and 2k+1 of stage s-1.
REQ-016: Every node register stores data, a valid bit and the remaining sel bits; the select travels with the data, so bank_sel_i may change every cycle.
REQ-017: adv = AND over all b of NOT(bank_valid_o[b] AND NOT bank_ready_i[b]).
REQ-018: When adv is 1, every node register loads its mux result, including valid=0 bubbles; when adv is 0, every register holds.
REQ-019: A PE beat is accepted only when pe_valid_i[p] and adv are both 1; a beat reaches bank_valid_o exactly N_STG adv-cycles later.
REQ-020: Multicast: one PE selected by several lanes is delivered to each of those lanes with the same latency.
REQ-021: A lane whose selected PE is not valid carries a bubble; bank_valid_o is 0 for that slot.
REQ-022: Under stall, pe_valid_i and pe_data_i are not sampled; the PE holds its beat until pe_ready_o is 1.
REQ-023: bank_data_o, bank_valid_o and idle_o come straight from registers; there is no combinational path from pe_*_i to bank_*_o.
REQ-024: idle_o is 1 exactly when every valid bit in every stage and lane is 0.

Reset
REQ-025: While rst_i is high, every valid bit is 0, data and sel registers are 0, bank_valid_o is 0, bank_data_o is 0 and idle_o is 1.
REQ-026: Reset asserted mid-stream discards all in-flight beats immediately (asynchronously); after release the pipeline starts empty.
REQ-027: pe_ready_o is 1 during reset (the pipeline is empty), but no beat is captured while rst_i is high.

Configuration
REQ-028: With STORE_XBAR_PERF_CNT_EN defined, the block adds output stall_cnt_o (32 bits, reset 0), which increments on each cycle where adv is 0 and saturates at 0xFFFF_FFFF.
REQ-029: Without STORE_XBAR_PERF_CNT_EN, stall_cnt_o and its counter do not exist and the remaining behaviour is unchanged.

Verification
REQ-030: Identity routing: N_PE=4, sel={3,2,1,0}, all banks ready, PE p sends 0xA0+p for one cycle -> two cycles later bank b shows 0xA0+b with valid, then idle_o returns to 1.
REQ-031: Broadcast: sel={2,2,2,2}, PE2 sends 0x1234 -> all four banks show 0x1234 with valid after 2 cycles; the other PEs' data never appears.
REQ-032: Backpressure: stream of 8 beats, bank_ready_i[1]=0 for 3 cycles mid-stream -> pe_ready_o is 0 for those 3 cycles, no beat is lost or duplicated on any bank, and stall_cnt_o=3 when the macro is defined.
REQ-033: Per-cycle select change: sel alternates between {0,1,2,3} and {3,2,1,0} each cycle -> each beat is delivered per the sel value present at its acceptance.
REQ-034: Reset mid-operation: assert rst_i with 2 beats in flight -> bank_valid_o is 0 immediately; after release, a new beat arrives with exactly 2-cycle latency.
REQ-035: Bubbles: PE1 valid only on alternate cycles with sel={1,1,1,1} -> bank_valid_o toggles 1/0 with matching data.

Source files
------------

// File: rtl/pea_banks_store_xbar.sv
// Store crossbar: each bank lane is a registered binary mux tree that picks
// one PE store stream. Optional stall counter behind STORE_XBAR_PERF_CNT_EN.
module pea_banks_store_xbar #(
    parameter  int N_PE   = 4,
    parameter  int DATA_W = 32,
    localparam int N_STG  = $clog2(N_PE)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_PE*DATA_W-1:0]   pe_data_i,
    input  logic [N_PE-1:0]          pe_valid_i,
    output logic [N_PE-1:0]          pe_ready_o,
    input  logic [N_PE*N_STG-1:0]    bank_sel_i,
    output logic [N_PE*DATA_W-1:0]   bank_data_o,
    output logic [N_PE-1:0]          bank_valid_o,
    input  logic [N_PE-1:0]          bank_ready_i,
`ifdef STORE_XBAR_PERF_CNT_EN
    output logic [31:0]              stall_cnt_o,
`endif
    output logic                     idle_o
);

    // Handshake: a PE beat transfers when pe_valid_i[p] && pe_ready_o[p]; a bank
    // beat transfers when bank_valid_o[b] && adv. The whole pipeline advances in
    // lockstep, so one stalled bank (valid && !ready) freezes every lane.
    logic adv;

    // Nodes of each lane are heap-indexed: 1 is the root (last stage), the
    // children of node i are 2i and 2i+1, nodes N_PE/2..N_PE-1 are stage 0.
    logic [DATA_W-1:0] nd_data  [N_PE][1:N_PE-1];
    logic              nd_valid [N_PE][1:N_PE-1];
    logic [N_STG-1:0]  nd_sel   [N_PE][1:N_PE-1];
    logic [DATA_W-1:0] nx_data  [N_PE][1:N_PE-1];
    logic              nx_valid [N_PE][1:N_PE-1];
    logic [N_STG-1:0]  nx_sel   [N_PE][1:N_PE-1];

    for (genvar b = 0; b < N_PE; b++) begin : g_lane
        logic [N_STG-1:0] sel_b;
        assign sel_b = bank_sel_i[b*N_STG +: N_STG];

        for (genvar i = 1; i < N_PE; i++) begin : g_node
            if (i >= N_PE/2) begin : g_leaf
                localparam int K = i - N_PE/2;
                assign nx_valid[b][i] = sel_b[0] ? pe_valid_i[2*K+1] : pe_valid_i[2*K];
                assign nx_data[b][i]  = sel_b[0] ? pe_data_i[(2*K+1)*DATA_W +: DATA_W]
                                                 : pe_data_i[(2*K)*DATA_W +: DATA_W];
                assign nx_sel[b][i]   = sel_b;
            end else begin : g_inner
                // Stage number of this node; it consumes that bit of the travelling select.
                localparam int S = N_STG - $clog2(i+1);
                logic pick;
                assign pick           = nd_sel[b][2*i][S];
                assign nx_valid[b][i] = pick ? nd_valid[b][2*i+1] : nd_valid[b][2*i];
                assign nx_data[b][i]  = pick ? nd_data[b][2*i+1]  : nd_data[b][2*i];
                assign nx_sel[b][i]   = nd_sel[b][2*i];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_PE; b++) begin
                for (int i = 1; i < N_PE; i++) begin
                    nd_data[b][i]  <= '0;
                    nd_valid[b][i] <= 1'b0;
                    nd_sel[b][i]   <= '0;
                end
            end
        end else if (adv) begin
            for (int b = 0; b < N_PE; b++) begin
                for (int i = 1; i < N_PE; i++) begin
                    nd_data[b][i]  <= nx_data[b][i];
                    nd_valid[b][i] <= nx_valid[b][i];
                    nd_sel[b][i]   <= nx_sel[b][i];
                end
            end
        end
    end

    always_comb begin
        bank_data_o  = '0;
        bank_valid_o = '0;
        for (int b = 0; b < N_PE; b++) begin
            bank_data_o[b*DATA_W +: DATA_W] = nd_data[b][1];
            bank_valid_o[b]                 = nd_valid[b][1];
        end
    end

    always_comb begin
        adv = 1'b1;
        for (int b = 0; b < N_PE; b++) begin
            if (bank_valid_o[b] && !bank_ready_i[b]) adv = 1'b0;
        end
    end

    assign pe_ready_o = {N_PE{adv}};

    // Idle looks at every node, including candidates a lane will later drop.
    always_comb begin
        idle_o = 1'b1;
        for (int b = 0; b < N_PE; b++) begin
            for (int i = 1; i < N_PE; i++) begin
                if (nd_valid[b][i]) idle_o = 1'b0;
            end
        end
    end

`ifdef STORE_XBAR_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (!adv && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
